// File: rtl/iob_vexriscv_bus_arb_pkg.sv
// Shared constants for the VexRiscv ibus/dbus arbiter: FSM state encoding
// and port indices, plus a helper to turn a one-hot grant into a port index.
package iob_vexriscv_bus_arb_pkg;

    localparam logic IDLE    = 1'b0;
    localparam logic RD_WAIT = 1'b1;

    localparam logic IBUS = 1'b0;
    localparam logic DBUS = 1'b1;

    // Two-port one-hot grant to index; with no grant this yields IBUS.
    function automatic logic grant_idx(input logic [1:0] grant);
        return grant[DBUS];
    endfunction

endpackage

// File: rtl/iob_reg_re.sv
// Generic register with clock enable, synchronous reset and load enable.
// arst_i is kept for interface compatibility; callers tie it low.
module iob_reg_re #(
    parameter int unsigned        DATA_W  = 1,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              arst_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] data_q;

    // Reset wins over clock enable so a reset always takes effect.
    always_ff @(posedge clk_i, posedge arst_i) begin
        if (arst_i) begin
            data_q <= RST_VAL;
        end else if (rst_i) begin
            data_q <= RST_VAL;
        end else if (cke_i && en_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/iob_vexriscv_arb_pick.sv
// Combinational two-way grant selection.
// With IOB_VEXRISCV_BUS_ARB_RR_EN defined, ptr_i holds the last granted port
// and the other port wins a tie; otherwise dbus always wins a tie.
import iob_vexriscv_bus_arb_pkg::*;

module iob_vexriscv_arb_pick (
    input  logic [1:0] req_i,
`ifdef IOB_VEXRISCV_BUS_ARB_RR_EN
    input  logic       ptr_i,
`endif
    output logic [1:0] grant_o
);

    // Grant the single requester, or resolve a tie by priority.
    always_comb begin
        grant_o = 2'b00;
        if (req_i == 2'b11) begin
`ifdef IOB_VEXRISCV_BUS_ARB_RR_EN
            grant_o = (ptr_i == DBUS) ? 2'b01 : 2'b10;
`else
            grant_o = 2'b10;
`endif
        end else begin
            grant_o = req_i;
        end
    end

endmodule

// File: rtl/iob_vexriscv_bus_arb.sv
// Two-to-one IOb arbiter sharing one memory port between the VexRiscv ibus
// (port 0) and dbus (port 1). One transaction in flight; read responses are
// steered back to the issuing port.
// Build option: IOB_VEXRISCV_BUS_ARB_RR_EN selects round-robin arbitration,
// otherwise dbus has fixed priority.
import iob_vexriscv_bus_arb_pkg::*;

module iob_vexriscv_bus_arb #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                cke_i,
    input  logic                s0_avalid_i,
    input  logic [ADDR_W-1:0]   s0_addr_i,
    input  logic [DATA_W-1:0]   s0_wdata_i,
    input  logic [DATA_W/8-1:0] s0_wstrb_i,
    output logic                s0_ready_o,
    output logic [DATA_W-1:0]   s0_rdata_o,
    output logic                s0_rvalid_o,
    input  logic                s1_avalid_i,
    input  logic [ADDR_W-1:0]   s1_addr_i,
    input  logic [DATA_W-1:0]   s1_wdata_i,
    input  logic [DATA_W/8-1:0] s1_wstrb_i,
    output logic                s1_ready_o,
    output logic [DATA_W-1:0]   s1_rdata_o,
    output logic                s1_rvalid_o,
    output logic                m_avalid_o,
    output logic [ADDR_W-1:0]   m_addr_o,
    output logic [DATA_W-1:0]   m_wdata_o,
    output logic [DATA_W/8-1:0] m_wstrb_o,
    input  logic                m_ready_i,
    input  logic [DATA_W-1:0]   m_rdata_i,
    input  logic                m_rvalid_i,
    output logic                busy_o,
    output logic                err_o
);

    logic       state_q, state_d;
    logic       owner_q, owner_d;
    logic       err_q, err_d;
    logic [1:0] req, grant;
    logic       idle, win, accept, acc_read, rsp;
    logic       rst;

    assign rst  = ~rst_n_i;
    assign idle = (state_q == IDLE);
    assign req  = {s1_avalid_i, s0_avalid_i};

`ifdef IOB_VEXRISCV_BUS_ARB_RR_EN
    logic ptr_q, ptr_d;

    iob_vexriscv_arb_pick u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // Remember the last accepted port so the other one wins the next tie.
    always_comb begin
        ptr_d = accept ? win : ptr_q;
    end

    iob_reg_re #(.DATA_W(1), .RST_VAL(1'b0)) u_ptr_reg (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (1'b0),
        .rst_i  (rst),
        .en_i   (1'b1),
        .data_i (ptr_d),
        .data_o (ptr_q)
    );
`else
    iob_vexriscv_arb_pick u_pick (
        .req_i   (req),
        .grant_o (grant)
    );
`endif

    assign win = grant_idx(grant);

    // Request path: pure mux, no added latency.
    assign m_avalid_o = idle & (|req);
    assign m_addr_o   = win ? s1_addr_i  : s0_addr_i;
    assign m_wdata_o  = win ? s1_wdata_i : s0_wdata_i;
    assign m_wstrb_o  = win ? s1_wstrb_i : s0_wstrb_i;

    assign accept     = m_avalid_o & m_ready_i;
    assign acc_read   = accept & ~(|m_wstrb_o);
    assign s0_ready_o = accept & grant[IBUS];
    assign s1_ready_o = accept & grant[DBUS];

    // Response path: rdata is shared, only rvalid is steered to the owner.
    assign rsp         = ~idle & m_rvalid_i;
    assign s0_rvalid_o = rsp & (owner_q == IBUS);
    assign s1_rvalid_o = rsp & (owner_q == DBUS);
    assign s0_rdata_o  = m_rdata_i;
    assign s1_rdata_o  = m_rdata_i;

    assign busy_o = (state_q == RD_WAIT);
    assign err_o  = err_q;

    // Next state: a read holds the port until its response; a stray response is flagged.
    always_comb begin
        state_d = state_q;
        if (rsp) begin
            state_d = IDLE;
        end else if (acc_read) begin
            state_d = RD_WAIT;
        end
        owner_d = acc_read ? win : owner_q;
        err_d   = err_q | (idle & m_rvalid_i);
    end

    iob_reg_re #(.DATA_W(1), .RST_VAL(IDLE)) u_state_reg (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (1'b0),
        .rst_i  (rst),
        .en_i   (1'b1),
        .data_i (state_d),
        .data_o (state_q)
    );

    iob_reg_re #(.DATA_W(1), .RST_VAL(IBUS)) u_owner_reg (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (1'b0),
        .rst_i  (rst),
        .en_i   (1'b1),
        .data_i (owner_d),
        .data_o (owner_q)
    );

    iob_reg_re #(.DATA_W(1), .RST_VAL(1'b0)) u_err_reg (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (1'b0),
        .rst_i  (rst),
        .en_i   (1'b1),
        .data_i (err_d),
        .data_o (err_q)
    );

endmodule

// File: tb/tb_iob_vexriscv_bus_arb.sv
// Self-checking bench for iob_vexriscv_bus_arb: directed scenarios followed by
// a randomized phase, all compared every cycle against a transaction-level
// model of the arbiter (busy flag, owner, last grant, sticky error).
module tb_iob_vexriscv_bus_arb;

    logic        clk = 1'b0;
    logic        rst_n, cke;
    logic        s0_avalid, s1_avalid;
    logic [31:0] s0_addr, s1_addr, s0_wdata, s1_wdata;
    logic [3:0]  s0_wstrb, s1_wstrb;
    logic        s0_ready_o, s1_ready_o, s0_rvalid_o, s1_rvalid_o;
    logic [31:0] s0_rdata_o, s1_rdata_o;
    logic        m_avalid_o, m_ready, m_rvalid, busy_o, err_o;
    logic [31:0] m_addr_o, m_wdata_o, m_rdata;
    logic [3:0]  m_wstrb_o;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit mdl_busy  = 1'b0;
    int mdl_owner = 0;
    int mdl_last  = 0;
    bit mdl_err   = 1'b0;

    always #5 clk = ~clk;

    iob_vexriscv_bus_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .cke_i       (cke),
        .s0_avalid_i (s0_avalid),
        .s0_addr_i   (s0_addr),
        .s0_wdata_i  (s0_wdata),
        .s0_wstrb_i  (s0_wstrb),
        .s0_ready_o  (s0_ready_o),
        .s0_rdata_o  (s0_rdata_o),
        .s0_rvalid_o (s0_rvalid_o),
        .s1_avalid_i (s1_avalid),
        .s1_addr_i   (s1_addr),
        .s1_wdata_i  (s1_wdata),
        .s1_wstrb_i  (s1_wstrb),
        .s1_ready_o  (s1_ready_o),
        .s1_rdata_o  (s1_rdata_o),
        .s1_rvalid_o (s1_rvalid_o),
        .m_avalid_o  (m_avalid_o),
        .m_addr_o    (m_addr_o),
        .m_wdata_o   (m_wdata_o),
        .m_wstrb_o   (m_wstrb_o),
        .m_ready_i   (m_ready),
        .m_rdata_i   (m_rdata),
        .m_rvalid_i  (m_rvalid),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Port that wins this cycle according to the model, -1 if none.
    function automatic int winner();
        if (mdl_busy) return -1;
        if (s0_avalid && s1_avalid) begin
`ifdef IOB_VEXRISCV_BUS_ARB_RR_EN
            return (mdl_last == 1) ? 0 : 1;
`else
            return 1;
`endif
        end
        if (s1_avalid) return 1;
        if (s0_avalid) return 0;
        return -1;
    endfunction

    // Mid-cycle: compare every output against the model.
    task automatic settle();
        int w;
        @(negedge clk);
        w = winner();
        chk("m_avalid", m_avalid_o, w >= 0);
        if (w >= 0) begin
            chk("m_addr",  m_addr_o,  (w == 1) ? s1_addr  : s0_addr);
            chk("m_wdata", m_wdata_o, (w == 1) ? s1_wdata : s0_wdata);
            chk("m_wstrb", m_wstrb_o, (w == 1) ? s1_wstrb : s0_wstrb);
        end
        chk("s0_ready",  s0_ready_o,  (w == 0) && m_ready);
        chk("s1_ready",  s1_ready_o,  (w == 1) && m_ready);
        chk("s0_rvalid", s0_rvalid_o, mdl_busy && m_rvalid && mdl_owner == 0);
        chk("s1_rvalid", s1_rvalid_o, mdl_busy && m_rvalid && mdl_owner == 1);
        chk("s0_rdata",  s0_rdata_o,  m_rdata);
        chk("s1_rdata",  s1_rdata_o,  m_rdata);
        chk("busy",      busy_o,      mdl_busy);
        chk("err",       err_o,       mdl_err);
    endtask

    // Clock edge: advance the model with the inputs the DUT just sampled.
    task automatic tick();
        int w;
        @(posedge clk);
        w = winner();
        if (!rst_n) begin
            mdl_busy = 0; mdl_owner = 0; mdl_last = 0; mdl_err = 0;
        end else if (cke) begin
            if (mdl_busy) begin
                if (m_rvalid) mdl_busy = 0;
            end else begin
                if (m_rvalid) mdl_err = 1;
                if (w >= 0 && m_ready) begin
                    mdl_last = w;
                    if (((w == 1) ? s1_wstrb : s0_wstrb) == 4'h0) begin
                        mdl_busy  = 1;
                        mdl_owner = w;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic clear_inputs();
        s0_avalid = 0; s0_addr = 0; s0_wdata = 0; s0_wstrb = 0;
        s1_avalid = 0; s1_addr = 0; s1_wdata = 0; s1_wstrb = 0;
        m_ready = 0; m_rvalid = 0; m_rdata = 0;
    endtask

    initial begin
        int exp_g;
        clear_inputs();
        rst_n = 0;
        cke   = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;

        // Reset state
        settle();
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        tick();

        // Single ibus read, memory latency 2
        s0_avalid = 1; s0_addr = 32'h100; s0_wstrb = 4'h0; m_ready = 1;
        settle();
        chk("rd_avalid", m_avalid_o, 1);
        chk("rd_accept", s0_ready_o, 1);
        tick();
        s0_avalid = 0; m_ready = 0;
        step();
        m_rvalid = 1; m_rdata = 32'hDEADBEEF;
        settle();
        chk("rd_rvalid", s0_rvalid_o, 1);
        chk("rd_rdata", s0_rdata_o, 32'hDEADBEEF);
        chk("rd_s1_quiet", s1_rvalid_o, 0);
        tick();
        m_rvalid = 0;

        // Simultaneous ibus read and dbus write: dbus first
        s0_avalid = 1; s0_addr = 32'h200; s0_wstrb = 4'h0;
        s1_avalid = 1; s1_addr = 32'h300; s1_wdata = 32'h12345678; s1_wstrb = 4'hF;
        m_ready = 1;
        settle();
        chk("sim_dbus_first", s1_ready_o, 1);
        chk("sim_wstrb", m_wstrb_o, 4'hF);
        chk("sim_wdata", m_wdata_o, 32'h12345678);
        tick();
        s1_avalid = 0;
        settle();
        chk("sim_ibus_next", s0_ready_o, 1);
        tick();
        s0_avalid = 0;
        m_rvalid = 1; m_rdata = $urandom;
        step();
        m_rvalid = 0;

        // Both ports write continuously for 6 transactions
        s0_avalid = 1; s0_addr = 32'h10; s0_wdata = 32'hA0A0A0A0; s0_wstrb = 4'h3;
        s1_avalid = 1; s1_addr = 32'h20; s1_wdata = 32'hB1B1B1B1; s1_wstrb = 4'hC;
        m_ready = 1;
        for (int i = 0; i < 6; i++) begin
`ifdef IOB_VEXRISCV_BUS_ARB_RR_EN
            exp_g = (i % 2 == 0) ? 1 : 0;
`else
            exp_g = 1;
`endif
            settle();
            chk("wr_grant_s1", s1_ready_o, exp_g == 1);
            chk("wr_grant_s0", s0_ready_o, exp_g == 0);
            tick();
        end
        clear_inputs();

        // dbus read outstanding while ibus keeps requesting
        s1_avalid = 1; s1_addr = 32'h400; s1_wstrb = 4'h0;
        s0_avalid = 1; s0_addr = 32'h500; s0_wstrb = 4'h0;
        m_ready = 1;
        settle();
        chk("ow_dbus_acc", s1_ready_o, 1);
        tick();
        s1_avalid = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ow_avalid", m_avalid_o, 0);
            chk("ow_s0_ready", s0_ready_o, 0);
            tick();
        end
        m_rvalid = 1; m_rdata = 32'hCAFEF00D;
        settle();
        chk("ow_rvalid", s1_rvalid_o, 1);
        chk("ow_no_grant", s0_ready_o, 0);
        tick();
        m_rvalid = 0;
        settle();
        chk("ow_ibus_grant", s0_ready_o, 1);
        tick();
        s0_avalid = 0;
        m_rvalid = 1;
        step();
        m_rvalid = 0;

        // Memory not ready for 5 cycles
        s1_avalid = 1; s1_addr = 32'h600; s1_wdata = 32'h55AA55AA; s1_wstrb = 4'h1;
        m_ready = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("stall_addr", m_addr_o, 32'h600);
            chk("stall_ready", s1_ready_o, 0);
            tick();
        end
        m_ready = 1;
        settle();
        chk("stall_accept", s1_ready_o, 1);
        tick();
        s1_avalid = 0;

        // Clock enable low: ready still combinational, state must not move
        s0_avalid = 1; s0_addr = 32'h700; s0_wstrb = 4'h0; m_ready = 1; cke = 0;
        settle();
        chk("cke_comb_ready", s0_ready_o, 1);
        tick();
        s0_avalid = 0;
        settle();
        chk("cke_hold_idle", busy_o, 0);
        tick();
        cke = 1;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            s0_avalid = 1'($urandom_range(0, 1));
            s1_avalid = 1'($urandom_range(0, 1));
            s0_addr   = $urandom; s1_addr = $urandom;
            s0_wdata  = $urandom; s1_wdata = $urandom;
            s0_wstrb  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            s1_wstrb  = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            m_ready   = ($urandom_range(0, 3) != 0);
            m_rvalid  = mdl_busy && ($urandom_range(0, 2) == 0);
            m_rdata   = $urandom;
            cke       = ($urandom_range(0, 7) != 0);
            rst_n     = ($urandom_range(0, 49) != 0);
            step();
        end
        clear_inputs();
        cke = 1; rst_n = 0;
        step();
        rst_n = 1;

        // Reset mid-read, then a late response
        s0_avalid = 1; s0_addr = 32'h800; s0_wstrb = 4'h0; m_ready = 1;
        step();
        clear_inputs();
        step();
        rst_n = 0;
        step();
        rst_n = 1;
        m_rvalid = 1; m_rdata = 32'h0BADBEEF;
        settle();
        chk("late_s0_rvalid", s0_rvalid_o, 0);
        chk("late_s1_rvalid", s1_rvalid_o, 0);
        tick();
        m_rvalid = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("err_sticky", err_o, 1);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iob_vexriscv_bus_arb.md
# iob_vexriscv_bus_arb

Two-to-one arbiter that shares one IOb native memory port between the VexRiscv wrapper's instruction bus (port 0) and data bus (port 1). It sits between the wrapper and the memory or interconnect. It muxes the winning request onto the shared port, keeps one transaction in flight, and routes the read response back to the port that issued it.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports; strobe width is DATA_W/8

Ports (x = 0 for ibus, 1 for dbus):
- clk_i  in  1  clock
- rst_n_i  in  1  reset, synchronous, active-low
- cke_i  in  1  clock enable; state holds when low
- sx_avalid_i  in  1  request valid
- sx_addr_i  in  ADDR_W  address
- sx_wdata_i  in  DATA_W  write data
- sx_wstrb_i  in  DATA_W/8  write strobe; all-zero means read
- sx_ready_o  out  1  request accepted this cycle
- sx_rdata_o  out  DATA_W  read data
- sx_rvalid_o  out  1  read data valid
- m_avalid_o  out  1  shared port request valid
- m_addr_o  out  ADDR_W  shared port address
- m_wdata_o  out  DATA_W  shared port write data
- m_wstrb_o  out  DATA_W/8  shared port write strobe
- m_ready_i  in  1  shared port accepts request
- m_rdata_i  in  DATA_W  shared port read data
- m_rvalid_i  in  1  shared port read data valid
- busy_o  out  1  read outstanding
- err_o  out  1  sticky flag: m_rvalid_i arrived with no read outstanding

## Operation
- FSM states:
  - IDLE:
    - Arbitrate among asserted sx_avalid_i.
    - Drive the winner's request combinationally on m_*.
    - On m_ready_i, the winner's sx_ready_o=1 and the transaction is accepted.
    - An accepted write (wstrb≠0) completes on acceptance; stay in IDLE.
    - An accepted read moves to RD_WAIT and registers owner = winner.
  - RD_WAIT:
    - m_avalid_o=0; both sx_ready_o=0.
    - On m_rvalid_i, assert sowner_rvalid_o; the owner's rdata = m_rdata_i.
    - Return to IDLE in the same cycle. Arbitration for the next request resumes the following cycle.
- Arbitration is per the Configuration section. The loser's sx_ready_o=0 and the loser's request must be held by the requester.
- Port addresses, data and strobes pass through unmodified. Boot and DDR address remapping stays in the wrapper.
- sx_rdata_o = m_rdata_i for both ports (shared). Only rvalid is steered by owner.
- busy_o = (state == RD_WAIT).
- err_o:
  - Set on m_rvalid_i in IDLE; that rvalid is dropped (no sx_rvalid_o).
  - Cleared only by reset.

## Timing
- Request path: zero added latency, combinational mux from sx_* to m_*.
- Response path: zero added latency, combinational from m_rvalid_i to sx_rvalid_o.
- A read costs acceptance cycle + memory latency + 1 idle arbitration cycle before the next grant.
- Back-to-back writes can be accepted every cycle.
- Reset values:
  - state=IDLE, owner=0, rr pointer=0, err_o=0, busy_o=0.
  - m_avalid_o=0, sx_ready_o=0, sx_rvalid_o=0.
- Reset mid-read: the outstanding read is abandoned. A late m_rvalid_i after reset sets err_o.
- If m_ready_i and m_rvalid_i are both high in RD_WAIT, the ready is ignored because m_avalid_o=0.
- With cke_i=0, all registers hold; combinational outputs still follow inputs.

## Configuration
- Macro IOB_VEXRISCV_BUS_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer gives priority to the port not granted last.
  - The pointer toggles only on an accepted transaction, so each port is guaranteed a grant within 2 transactions.
- Undefined: fixed priority, dbus (port 1) over ibus; no pointer register.

## Structure
- Shared package iob_vexriscv_bus_arb_pkg:
  - state encoding constants (IDLE=1'b0, RD_WAIT=1'b1);
  - port index constants (IBUS=0, DBUS=1).
- All registers are built from iob_reg_re (rst_i driven by ~rst_n_i, arst_i tied 0).
- One sub-module is natural: iob_vexriscv_arb_pick. It is combinational: requests, pointer → grant one-hot.

## Test plan
- Single ibus read at addr 0x100 with memory latency 2:
  - m_avalid_o=1 and s0_ready_o=1 on accept;
  - s0_rvalid_o=1 two cycles later with rdata 0xDEADBEEF;
  - s1_rvalid_o stays 0.
- Simultaneous ibus read and dbus write (wstrb 0xF, data 0x12345678), fixed priority build:
  - dbus is accepted first, with m_wstrb_o=0xF;
  - ibus is accepted the next cycle.
- RR build, both ports request continuously for 6 writes:
  - grants alternate 1,0,1,0,1,0 when starting with pointer=0 and dbus priority;
  - neither port waits more than 1 transaction.
- dbus read outstanding while ibus asserts avalid:
  - m_avalid_o=0 and s0_ready_o=0 until m_rvalid_i;
  - ibus is granted the following cycle.
- m_ready_i held low for 5 cycles with a dbus request:
  - m_addr_o stays stable;
  - s1_ready_o=0 for 5 cycles, then 1 on the cycle m_ready_i rises.
- Reset mid-read, then m_rvalid_i pulses:
  - no sx_rvalid_o;
  - err_o=1 and stays 1 until the next reset.
